// File: rtl/writeback_stage.sv
// WB stage: MEM/WB pipeline buffer, write-back source select, last-write bypass record
// and retired-instruction counter.
module writeback_stage #(
    parameter int W  = 16,
    parameter int N  = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic [2:0]    mem_WB_signals,
    input  logic [W-1:0]  mem_alu_result,
    input  logic [W-1:0]  mem_read_data,
    input  logic [W-1:0]  mem_in_port,
    input  logic [W-1:0]  mem_imm,
    input  logic [N-1:0]  mem_dst,
    output logic          regWrite,
    output logic [W-1:0]  WD,
    output logic [N-1:0]  WA,
    output logic          byp_valid,
    output logic [N-1:0]  byp_addr,
    output logic [W-1:0]  byp_data,
    output logic [CW-1:0] retired_count
);

    logic          v_q, v_d;
    logic          rw_q, rw_d;
    logic [1:0]    sel_q, sel_d;
    logic [W-1:0]  alu_q, alu_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic [W-1:0]  inp_q, inp_d;
    logic [W-1:0]  imm_q, imm_d;
    logic [N-1:0]  dst_q, dst_d;

    logic          byp_valid_q, byp_valid_d;
    logic [N-1:0]  byp_addr_q, byp_addr_d;
    logic [W-1:0]  byp_data_q, byp_data_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;

    function automatic logic [W-1:0] select_wd(
        input logic [1:0]   sel,
        input logic [W-1:0] alu,
        input logic [W-1:0] rdata,
        input logic [W-1:0] inp,
        input logic [W-1:0] imm
    );
        logic [W-1:0] r;
        case (sel)
            2'b00:   r = alu;
            2'b01:   r = rdata;
            2'b10:   r = inp;
            default: r = imm;
        endcase
        return r;
    endfunction

    // Buffer next state: flush beats stall; a bubble clears every field.
    always_comb begin
        load    = !flush && !stall;
        v_d     = v_q;
        rw_d    = rw_q;
        sel_d   = sel_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        inp_d   = inp_q;
        imm_d   = imm_q;
        dst_d   = dst_q;
        if (flush) begin
            v_d     = 1'b0;
            rw_d    = 1'b0;
            sel_d   = 2'b00;
            alu_d   = '0;
            rdata_d = '0;
            inp_d   = '0;
            imm_d   = '0;
            dst_d   = '0;
        end else if (!stall) begin
            v_d     = mem_valid;
            rw_d    = mem_WB_signals[2] & mem_valid;
            sel_d   = mem_WB_signals[1:0];
            alu_d   = mem_alu_result;
            rdata_d = mem_read_data;
            inp_d   = mem_in_port;
            imm_d   = mem_imm;
            dst_d   = mem_dst;
        end
    end

    always_comb begin
        regWrite = v_q & rw_q;
        WA       = dst_q;
        WD       = select_wd(sel_q, alu_q, rdata_q, inp_q, imm_q);
    end

    // A stalled write repeats every cycle; it is recorded only when it finally leaves.
    always_comb begin
        byp_valid_d = byp_valid_q;
        byp_addr_d  = byp_addr_q;
        byp_data_d  = byp_data_q;
        if (regWrite && !stall) begin
            byp_valid_d = 1'b1;
            byp_addr_d  = WA;
            byp_data_d  = WD;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load && mem_valid) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= 1'b0;
            rw_q        <= 1'b0;
            sel_q       <= 2'b00;
            alu_q       <= '0;
            rdata_q     <= '0;
            inp_q       <= '0;
            imm_q       <= '0;
            dst_q       <= '0;
            byp_valid_q <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            v_q         <= v_d;
            rw_q        <= rw_d;
            sel_q       <= sel_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            inp_q       <= inp_d;
            imm_q       <= imm_d;
            dst_q       <= dst_d;
            byp_valid_q <= byp_valid_d;
            byp_addr_q  <= byp_addr_d;
            byp_data_q  <= byp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign byp_valid     = byp_valid_q;
    assign byp_addr      = byp_addr_q;
    assign byp_data      = byp_data_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: each driven cycle pushes its expected outputs,
// which are popped and compared one cycle later.
module tb_writeback_stage;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int CW = 10;

    logic          clk;
    logic          rst, stall, flush, mem_valid;
    logic [2:0]    mem_WB_signals;
    logic [W-1:0]  mem_alu_result, mem_read_data, mem_in_port, mem_imm;
    logic [N-1:0]  mem_dst;
    logic          regWrite, byp_valid;
    logic [W-1:0]  WD, byp_data;
    logic [N-1:0]  WA, byp_addr;
    logic [CW-1:0] retired_count;

    writeback_stage #(.W(W), .N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_WB_signals(mem_WB_signals), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .mem_in_port(mem_in_port), .mem_imm(mem_imm),
        .mem_dst(mem_dst), .regWrite(regWrite), .WD(WD), .WA(WA),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [N-1:0]  wa;
        logic [W-1:0]  wd;
        logic          bv;
        logic [N-1:0]  ba;
        logic [W-1:0]  bd;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Expected architectural state as seen from the outputs
    logic          m_rw, m_bv;
    logic [N-1:0]  m_wa, m_ba;
    logic [W-1:0]  m_wd, m_bd;
    logic [CW-1:0] m_cnt;

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic [2:0] sig, input logic [W-1:0] a, input logic [W-1:0] rd,
                         input logic [W-1:0] ip, input logic [W-1:0] im, input logic [N-1:0] d);
        exp_t e;
        rst = r; stall = s; flush = f; mem_valid = v; mem_WB_signals = sig;
        mem_alu_result = a; mem_read_data = rd; mem_in_port = ip; mem_imm = im; mem_dst = d;
        if (r) begin
            m_bv = 1'b0; m_ba = '0; m_bd = '0;
        end else if (m_rw && !s) begin
            m_bv = 1'b1; m_ba = m_wa; m_bd = m_wd;
        end
        if (r) begin
            m_rw = 1'b0; m_wa = '0; m_wd = '0; m_cnt = '0;
        end else if (f) begin
            m_rw = 1'b0; m_wa = '0; m_wd = '0;
        end else if (!s) begin
            m_rw = sig[2] && v;
            m_wa = d;
            m_wd = (sig[1:0] == 2'd0) ? a : (sig[1:0] == 2'd1) ? rd : (sig[1:0] == 2'd2) ? ip : im;
            if (v) m_cnt = m_cnt + 1'b1;
        end
        e.rw = m_rw; e.wa = m_wa; e.wd = m_wd;
        e.bv = m_bv; e.ba = m_ba; e.bd = m_bd; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), W'($urandom),
                  W'($urandom), W'($urandom), W'($urandom), N'($urandom));
            e = sb.pop_front();
            checks += 5;
            if (regWrite !== e.rw) begin failures++; $display("FAIL reset_rw: got=%0b exp=%0b", regWrite, e.rw); end
            if (WD !== e.wd) begin failures++; $display("FAIL reset_wd: got=%h exp=%h", WD, e.wd); end
            if (WA !== e.wa) begin failures++; $display("FAIL reset_wa: got=%0d exp=%0d", WA, e.wa); end
            if (byp_valid !== e.bv) begin failures++; $display("FAIL reset_byp_valid: got=%0b exp=%0b", byp_valid, e.bv); end
            if (retired_count !== e.cnt) begin failures++; $display("FAIL reset_count: got=%0d exp=%0d", retired_count, e.cnt); end
        end
    endtask

    task automatic test_mux();
        exp_t e;
        logic [W-1:0] want [4];
        want[0] = 16'h1234; want[1] = 16'hBEEF; want[2] = 16'h00A5; want[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, {1'b1, 2'(i)}, 16'h1234, 16'hBEEF, 16'h00A5, 16'hFFFF, 3'd3);
            e = sb.pop_front();
            checks += 6;
            if (regWrite !== e.rw) begin failures++; $display("FAIL mux_rw%0d: got=%0b exp=%0b", i, regWrite, e.rw); end
            if (WA !== e.wa) begin failures++; $display("FAIL mux_wa%0d: got=%0d exp=%0d", i, WA, e.wa); end
            if (WD !== want[i]) begin failures++; $display("FAIL mux_wd%0d: got=%h exp=%h", i, WD, want[i]); end
            if (byp_valid !== e.bv || byp_addr !== e.ba || byp_data !== e.bd) begin
                failures++;
                $display("FAIL mux_byp%0d: got=%0b/%0d/%h exp=%0b/%0d/%h", i, byp_valid, byp_addr, byp_data, e.bv, e.ba, e.bd);
            end
            if (retired_count !== e.cnt) begin failures++; $display("FAIL mux_count%0d: got=%0d exp=%0d", i, retired_count, e.cnt); end
            if (WD !== e.wd) begin failures++; $display("FAIL mux_model_wd%0d: got=%h exp=%h", i, WD, e.wd); end
        end
        checks++;
        if (retired_count !== CW'(4)) begin failures++; $display("FAIL mux_total: got=%0d exp=4", retired_count); end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [CW-1:0] c0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 16'h0042, 16'h1111, 16'h2222, 16'h3333, 3'd5);
        e = sb.pop_front();
        c0 = retired_count;
        checks += 2;
        if (regWrite !== 1'b1 || WA !== 3'd5 || WD !== 16'h0042) begin
            failures++; $display("FAIL stall_load: got=%0b/%0d/%h exp=1/5/0042", regWrite, WA, WD);
        end
        if (byp_addr !== e.ba || byp_data !== e.bd) begin
            failures++; $display("FAIL stall_load_byp: got=%0d/%h exp=%0d/%h", byp_addr, byp_data, e.ba, e.bd);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 3'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), N'($urandom));
            e = sb.pop_front();
            checks += 3;
            if (regWrite !== 1'b1 || WA !== 3'd5 || WD !== 16'h0042) begin
                failures++; $display("FAIL stall_hold%0d: got=%0b/%0d/%h exp=1/5/0042", i, regWrite, WA, WD);
            end
            if (byp_valid !== e.bv || byp_addr !== e.ba || byp_data !== e.bd) begin
                failures++;
                $display("FAIL stall_byp%0d: got=%0b/%0d/%h exp=%0b/%0d/%h", i, byp_valid, byp_addr, byp_data, e.bv, e.ba, e.bd);
            end
            if (retired_count !== c0) begin failures++; $display("FAIL stall_count%0d: got=%0d exp=%0d", i, retired_count, c0); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 16'h7777, 16'h0, 16'h0, 16'h0, 3'd2);
        e = sb.pop_front();
        checks += 3;
        if (regWrite !== 1'b0) begin failures++; $display("FAIL flush_rw: got=%0b exp=0", regWrite); end
        if (retired_count !== e.cnt) begin failures++; $display("FAIL flush_count: got=%0d exp=%0d", retired_count, e.cnt); end
        if (byp_valid !== e.bv || byp_addr !== e.ba || byp_data !== e.bd) begin
            failures++;
            $display("FAIL flush_byp: got=%0b/%0d/%h exp=%0b/%0d/%h", byp_valid, byp_addr, byp_data, e.bv, e.ba, e.bd);
        end
    endtask

    task automatic test_bubble();
        exp_t e;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 16'h0, 16'h5A5A, 16'h0, 16'h0, 3'd6);
        e = sb.pop_front();
        checks++;
        if (regWrite !== 1'b1 || WA !== 3'd6 || WD !== 16'h5A5A) begin
            failures++; $display("FAIL bubble_pre: got=%0b/%0d/%h exp=1/6/5a5a", regWrite, WA, WD);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 16'hABCD, 16'h0, 16'h0, 16'h0, 3'd1);
        e = sb.pop_front();
        checks += 3;
        if (regWrite !== 1'b0) begin failures++; $display("FAIL bubble_rw: got=%0b exp=0", regWrite); end
        if (retired_count !== e.cnt) begin failures++; $display("FAIL bubble_count: got=%0d exp=%0d", retired_count, e.cnt); end
        if (byp_valid !== 1'b1 || byp_addr !== 3'd6 || byp_data !== 16'h5A5A) begin
            failures++; $display("FAIL bubble_byp: got=%0b/%0d/%h exp=1/6/5a5a", byp_valid, byp_addr, byp_data);
        end
    endtask

    task automatic test_wrap_reset();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
        e = sb.pop_front();
        for (int i = 1; i < (1 << CW); i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, W'(i), 16'h0, 16'h0, 16'h0, 3'd0);
            e = sb.pop_front();
            checks++;
            if (retired_count !== e.cnt) begin
                failures++; $display("FAIL wrap_count%0d: got=%0d exp=%0d", i, retired_count, e.cnt);
            end
        end
        checks++;
        if (retired_count !== {CW{1'b1}}) begin failures++; $display("FAIL wrap_full: got=%0d exp=%0d", retired_count, {CW{1'b1}}); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 16'h0, 16'h0, 16'h0, 16'hC0DE, 3'd7);
        e = sb.pop_front();
        checks += 2;
        if (retired_count !== '0) begin failures++; $display("FAIL wrap_zero: got=%0d exp=0", retired_count); end
        if (regWrite !== 1'b1 || WA !== 3'd7 || WD !== 16'hC0DE) begin
            failures++; $display("FAIL wrap_write: got=%0b/%0d/%h exp=1/7/c0de", regWrite, WA, WD);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 16'h0, 16'h0, 16'h0, 16'h1234, 3'd4);
        e = sb.pop_front();
        checks += 3;
        if (regWrite !== 1'b0 || WA !== e.wa || WD !== e.wd) begin
            failures++; $display("FAIL midreset_out: got=%0b/%0d/%h exp=0/%0d/%h", regWrite, WA, WD, e.wa, e.wd);
        end
        if (byp_valid !== 1'b0) begin failures++; $display("FAIL midreset_byp: got=%0b exp=0", byp_valid); end
        if (retired_count !== e.cnt) begin failures++; $display("FAIL midreset_count: got=%0d exp=%0d", retired_count, e.cnt); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_WB_signals = '0;
        mem_alu_result = '0; mem_read_data = '0; mem_in_port = '0; mem_imm = '0; mem_dst = '0;
        m_rw = 1'b0; m_wa = '0; m_wd = '0; m_bv = 1'b0; m_ba = '0; m_bd = '0; m_cnt = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_mux();
        test_stall();
        test_flush();
        test_bubble();
        test_wrap_reset();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left: got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
